// File: rtl/sipo_latch_receiver_pkg.sv
// Shared definitions for the SIPO latch receiver and its PISO transmitter peer:
// default word length, bit-order selectors and a ceil(log2) helper.
package sipo_latch_receiver_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-order selectors; the PISO transmitter shifts its top bit out first.
    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // Number of bits needed to encode values 0..value-1 (minimum 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sipo_latch_receiver_if.sv
// Serial input, word output handshake and status bundle of the SIPO receiver.
// The master side feeds serial data and consumes words; the slave is the receiver.
interface sipo_latch_receiver_if
    import sipo_latch_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CNT_W = clog2(WIDTH + 1);

    logic             ds;
    logic             ce;
    logic             sync;
    logic [WIDTH-1:0] p_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             clr_ovr;
    logic             qs;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output ds, ce, sync, out_ready, clr_ovr,
        input  p_out, out_valid, overrun, qs, bit_cnt
    );

    modport slave (
        input  ds, ce, sync, out_ready, clr_ovr,
        output p_out, out_valid, overrun, qs, bit_cnt
    );

endinterface

// File: rtl/sipo_latch_receiver_shift_reg.sv
// WIDTH-bit serial-in shift register with enable and selectable bit order.
// Exposes the current contents, the contents after the pending shift and the
// last stage (cascade output).
module sipo_shift_reg
    import sipo_latch_receiver_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ce,
    input  logic             ds,
    output logic [WIDTH-1:0] sr,
    output logic [WIDTH-1:0] sr_shifted,
    output logic             qs
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;

    // Per-stage next value: new bit enters at one end, everything moves one
    // place toward the cascade stage at the other end.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
        if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_in
                assign sr_next[gi] = ds;
            end else begin : g_mid
                assign sr_next[gi] = sr_reg[gi-1];
            end
        end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_in
                assign sr_next[gi] = ds;
            end else begin : g_mid
                assign sr_next[gi] = sr_reg[gi+1];
            end
        end
    end

    if (MSB_FIRST) begin : g_qs_msb
        assign qs = sr_reg[WIDTH-1];
    end else begin : g_qs_lsb
        assign qs = sr_reg[0];
    end

    assign sr         = sr_reg;
    assign sr_shifted = sr_next;

    // Shift on enabled clocks; reset clears every stage.
    always_ff @(posedge clk) begin
        if (srst) begin
            sr_reg <= '0;
        end else if (ce) begin
            sr_reg <= sr_next;
        end
    end

endmodule

// File: rtl/sipo_latch_receiver.sv
// Serial-in/parallel-out receiver: counts enabled bits, moves each complete
// word into a holding register offered on a valid/ready handshake, and flags
// words lost because the consumer had not taken the previous one.
module sipo_latch_receiver
    import sipo_latch_receiver_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic                  cp,
    input  logic                  mr,
    sipo_latch_receiver_if.slave  bus
);

    localparam int               CNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [WIDTH-1:0] sr_now;
    logic [WIDTH-1:0] word;
    logic             qs_wire;

    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [WIDTH-1:0] p_out_reg, p_out_next;
    logic             valid_reg, valid_next;
    logic             ovr_reg,   ovr_next;

    logic word_done;
    logic load_word;
    logic drop_word;
    logic accept;

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (cp),
        .srst       (mr),
        .ce         (bus.ce),
        .ds         (bus.ds),
        .sr         (sr_now),
        .sr_shifted (word),
        .qs         (qs_wire)
    );

    // A word completes on the enabled edge that samples its last bit; a sync
    // edge always starts a new word instead, so it never completes one.
    assign word_done = bus.ce && !bus.sync && (cnt_reg == LAST_BIT);
    assign accept    = valid_reg && bus.out_ready;
    assign load_word = word_done && (!valid_reg || bus.out_ready);
    assign drop_word = word_done && valid_reg && !bus.out_ready;

    // Bit counter, holding register, handshake and sticky overrun next-state.
    always_comb begin
        cnt_next   = cnt_reg;
        p_out_next = p_out_reg;
        valid_next = valid_reg;
        ovr_next   = ovr_reg;

        if (bus.sync) begin
            cnt_next = bus.ce ? ONE : '0;
        end else if (bus.ce) begin
            cnt_next = word_done ? '0 : cnt_reg + ONE;
        end

        if (load_word) begin
            p_out_next = word;
            valid_next = 1'b1;
        end else if (accept) begin
            valid_next = 1'b0;
        end

        if (drop_word) begin
            ovr_next = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_next = 1'b0;
        end
    end

    // State registers; master reset discards partial and pending words.
    always_ff @(posedge cp) begin
        if (mr) begin
            cnt_reg   <= '0;
            p_out_reg <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            p_out_reg <= p_out_next;
            valid_reg <= valid_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign bus.p_out     = p_out_reg;
    assign bus.out_valid = valid_reg;
    assign bus.overrun   = ovr_reg;
    assign bus.bit_cnt   = cnt_reg;
    assign bus.qs        = qs_wire;

    // Parallel contents are only needed through the shifted word and qs.
    logic unused_sr;
    assign unused_sr = ^sr_now;

endmodule

// File: tb/tb_sipo_latch_receiver.sv
// Bench for sipo_latch_receiver: one MSB-first and one LSB-first instance fed
// the same serial stream, checked every cycle against a bit-history model and
// at key points against hand-computed words.
module tb_sipo_latch_receiver;
    import sipo_latch_receiver_pkg::*;

    localparam int W  = 8;
    localparam int CW = clog2(W + 1);

    logic cp = 1'b0;
    logic mr = 1'b1;
    logic ds = 1'b0, ce = 1'b0, sync = 1'b0, rdy = 1'b0, clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    sipo_latch_receiver_if #(.WIDTH(W)) bm ();
    sipo_latch_receiver_if #(.WIDTH(W)) bl ();

    assign bm.ds = ds;  assign bm.ce = ce;  assign bm.sync = sync;
    assign bm.out_ready = rdy;  assign bm.clr_ovr = clr;
    assign bl.ds = ds;  assign bl.ce = ce;  assign bl.sync = sync;
    assign bl.out_ready = rdy;  assign bl.clr_ovr = clr;

    sipo_latch_receiver #(.WIDTH(W), .MSB_FIRST(ORDER_MSB_FIRST)) dut_msb (
        .cp  (cp),
        .mr  (mr),
        .bus (bm)
    );

    sipo_latch_receiver #(.WIDTH(W), .MSB_FIRST(ORDER_LSB_FIRST)) dut_lsb (
        .cp  (cp),
        .mr  (mr),
        .bus (bl)
    );

    always #5 cp = ~cp;

    // ---------------- behavioural model ----------------
    // hist holds the most recent (up to W) bits shifted in, oldest first.
    bit         hist[$];
    int         m_cnt   = 0;
    logic [W-1:0] m_pm  = '0;
    logic [W-1:0] m_pl  = '0;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;

    function automatic logic [W-1:0] hist_word(input bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < W; k++) begin
            if (k < hist.size()) begin
                if (msb_first) w[W-1-k] = hist[k];
                else           w[k]     = hist[k];
            end
        end
        return w;
    endfunction

    function automatic bit model_qs();
        return (hist.size() == W) ? hist[0] : 1'b0;
    endfunction

    always @(posedge cp) begin : model
        bit done;
        bit dropped;
        if (mr) begin
            hist.delete();
            m_cnt = 0; m_pm = '0; m_pl = '0; m_valid = 0; m_ovr = 0;
        end else begin
            done    = ce && !sync && (m_cnt == W - 1);
            dropped = done && m_valid && !rdy;
            if (ce) begin
                hist.push_back(ds);
                if (hist.size() > W) void'(hist.pop_front());
            end
            if (done && !dropped) begin
                m_pm = hist_word(1'b1);
                m_pl = hist_word(1'b0);
                m_valid = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (dropped)  m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            if (sync)      m_cnt = ce ? 1 : 0;
            else if (done) m_cnt = 0;
            else if (ce)   m_cnt = m_cnt + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    // Every cycle, away from the active edge, both instances against the model.
    always @(negedge cp) begin : compare
        cmp("msb.p_out",     32'(bm.p_out),     32'(m_pm));
        cmp("msb.out_valid", 32'(bm.out_valid), 32'(m_valid));
        cmp("msb.overrun",   32'(bm.overrun),   32'(m_ovr));
        cmp("msb.bit_cnt",   32'(bm.bit_cnt),   32'(m_cnt));
        cmp("msb.qs",        32'(bm.qs),        32'(model_qs()));
        cmp("lsb.p_out",     32'(bl.p_out),     32'(m_pl));
        cmp("lsb.out_valid", 32'(bl.out_valid), 32'(m_valid));
        cmp("lsb.overrun",   32'(bl.overrun),   32'(m_ovr));
        cmp("lsb.bit_cnt",   32'(bl.bit_cnt),   32'(m_cnt));
        cmp("lsb.qs",        32'(bl.qs),        32'(model_qs()));
    end

    // Literal check of a DUT value and the matching model value.
    task automatic lit(input string nm, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] exp);
        cmp({nm, ".dut"},   dut_v, exp);
        cmp({nm, ".model"}, mdl_v, exp);
    endtask

    // ---------------- stimulus ----------------
    task automatic cyc(input logic d, input logic c, input logic s,
                       input logic r, input logic cl);
        ds = d; ce = c; sync = s; rdy = r; clr = cl;
        @(negedge cp);
    endtask

    task automatic shift_bits(input logic [7:0] b, input int n, input logic r);
        for (int i = 7; i > 7 - n; i--) cyc(b[i], 1'b1, 1'b0, r, 1'b0);
    endtask

    initial begin
        mr = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        mr = 1'b0;
        lit("rst_p_out", 32'(bm.p_out),     32'(m_pm),    32'h0);
        lit("rst_valid", 32'(bm.out_valid), 32'(m_valid), 32'h0);
        lit("rst_cnt",   32'(bm.bit_cnt),   32'(m_cnt),   32'h0);
        lit("rst_qs",    32'(bm.qs),        32'(model_qs()), 32'h0);

        // First word, consumer stalled.
        shift_bits(8'hA5, 8, 1'b0);
        lit("a5_msb",   32'(bm.p_out),     32'(m_pm),    32'hA5);
        lit("a5_lsb",   32'(bl.p_out),     32'(m_pl),    32'hA5);
        lit("a5_valid", 32'(bm.out_valid), 32'(m_valid), 32'h1);
        lit("a5_cnt",   32'(bm.bit_cnt),   32'(m_cnt),   32'h0);

        // Second word dropped; clear on the same edge loses to the set.
        shift_bits(8'h3C, 7, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        lit("ovr_p_out", 32'(bm.p_out),   32'(m_pm),  32'hA5);
        lit("ovr_set",   32'(bm.overrun), 32'(m_ovr), 32'h1);
        cyc(0, 0, 0, 0, 1);
        lit("ovr_clr",   32'(bm.overrun), 32'(m_ovr), 32'h0);
        cyc(0, 0, 0, 1, 0);
        lit("acc_valid", 32'(bm.out_valid), 32'(m_valid), 32'h0);
        lit("acc_hold",  32'(bm.p_out),     32'(m_pm),    32'hA5);

        // Bit order distinguishes the two instances.
        shift_bits(8'hC1, 8, 1'b0);
        lit("c1_msb", 32'(bm.p_out), 32'(m_pm), 32'hC1);
        lit("c1_lsb", 32'(bl.p_out), 32'(m_pl), 32'h83);

        // Back-to-back with the consumer ready.
        shift_bits(8'h01, 8, 1'b1);
        lit("b2b_01_msb", 32'(bm.p_out),     32'(m_pm),    32'h01);
        lit("b2b_01_lsb", 32'(bl.p_out),     32'(m_pl),    32'h80);
        lit("b2b_valid",  32'(bm.out_valid), 32'(m_valid), 32'h1);
        shift_bits(8'hFF, 7, 1'b0);
        lit("b2b_held",   32'(bm.out_valid), 32'(m_valid), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        lit("b2b_ff",     32'(bm.p_out),     32'(m_pm),    32'hFF);
        lit("b2b_nobub",  32'(bm.out_valid), 32'(m_valid), 32'h1);
        lit("b2b_noovr",  32'(bm.overrun),   32'(m_ovr),   32'h0);
        cyc(0, 0, 0, 1, 0);

        // Sync mid-word restarts the count with the current bit as bit 0.
        shift_bits(8'hFF, 5, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        lit("sync_cnt",   32'(bm.bit_cnt),   32'(m_cnt),   32'h1);
        lit("sync_noword", 32'(bm.out_valid), 32'(m_valid), 32'h0);
        shift_bits(8'h00, 7, 1'b0);
        lit("sync_msb", 32'(bm.p_out), 32'(m_pm), 32'h80);
        lit("sync_lsb", 32'(bl.p_out), 32'(m_pl), 32'h01);

        // Reset mid-word with a word pending.
        shift_bits(8'hF0, 4, 1'b0);
        mr = 1'b1;
        cyc(1, 1, 0, 0, 0);
        mr = 1'b0;
        lit("mr_p_out", 32'(bm.p_out),     32'(m_pm),    32'h0);
        lit("mr_valid", 32'(bm.out_valid), 32'(m_valid), 32'h0);
        lit("mr_cnt",   32'(bm.bit_cnt),   32'(m_cnt),   32'h0);
        shift_bits(8'h5A, 7, 1'b0);
        lit("5a_early", 32'(bm.out_valid), 32'(m_valid), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lit("5a_word",  32'(bm.p_out),     32'(m_pm),    32'h5A);
        lit("5a_valid", 32'(bm.out_valid), 32'(m_valid), 32'h1);

        // Sync on what would have been the last bit produces no word.
        cyc(0, 0, 0, 1, 0);
        shift_bits(8'hFF, 7, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        lit("sync_last_cnt",   32'(bm.bit_cnt),   32'(m_cnt),   32'h1);
        lit("sync_last_valid", 32'(bm.out_valid), 32'(m_valid), 32'h0);
        cyc(0, 0, 1, 0, 0);
        lit("sync_idle_cnt", 32'(bm.bit_cnt), 32'(m_cnt), 32'h0);
        cyc(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
